ctl_relogio: RTL
================

CTL_RELOGIO -- requirements
Module: ctl_relogio

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000: clock cycles per second.
REQ-002 SHALL have parameter SEC_PER_MIN, default 60: seconds per minute tick.
REQ-003 SHALL have parameter REPEAT_TICKS, default 25000000: auto-repeat interval while ctl_btn_inc is held.
REQ-004 SHALL have parameter BLINK_TICKS, default 12500000: half-period of ctl_blink in set modes.
REQ-005 SHALL have port ctl_clock, input, 1 bit: single clock; one clock, all state on its rising edge.
REQ-006 SHALL have port ctl_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port ctl_btn_mode, input, 1 bit: mode button, level, already synchronous and debounced.
REQ-008 SHALL have port ctl_btn_inc, input, 1 bit: increment button, level, already synchronous and debounced.
REQ-009 SHALL have port ctl_enable, output, 1 bit: enable to minute/hour counters.
REQ-010 SHALL have port ctl_add_min, output, 1 bit: one-cycle minute-increment pulse.
REQ-011 SHALL have port ctl_add_hor, output, 1 bit: one-cycle direct hour-increment pulse (set mode only).
REQ-012 SHALL have port ctl_carry_en, output, 1 bit: when 0, the hour counter ignores the minute carry.
REQ-013 SHALL have port ctl_mode, output, 2 bits: 0=RUN, 1=SET_HOR, 2=SET_MIN.
REQ-014 SHALL have port ctl_sec, output, 6 bits: current seconds value, 0..SEC_PER_MIN-1.
REQ-015 SHALL have port ctl_blink, output, 1 bit: display-visible flag for the field being set.

Function
REQ-016 SHALL implement the FSM RUN -> SET_HOR -> SET_MIN -> RUN, advancing one state per rising edge of ctl_btn_mode (current sample 1, previous sample 0).
REQ-017 SHALL, in RUN, count a prescaler 0..TICKS_PER_SEC-1, wrapping to 0; at the wrap, ctl_sec increments, wrapping SEC_PER_MIN-1 -> 0.
REQ-018 SHALL, in RUN, assert ctl_add_min for exactly 1 cycle, registered, on the edge where ctl_sec wraps to 0.
REQ-019 SHALL, in SET_HOR/SET_MIN, freeze the prescaler and hold ctl_sec at 0; both SHALL clear to 0 on any transition into or out of RUN.
REQ-020 SHALL, in SET_MIN, assert a 1-cycle ctl_add_min on each ctl_btn_inc rising edge, plus auto-repeat pulses every REPEAT_TICKS cycles while the button stays high.
REQ-021 SHALL, in SET_HOR, do the same as REQ-020 on ctl_add_hor; ctl_add_min SHALL stay 0 in SET_HOR.
REQ-022 SHALL keep ctl_add_hor = 0 in RUN and SET_MIN.
REQ-023 SHALL drive ctl_carry_en = 1 in RUN and 0 in both set modes, so a minute wrap in SET_MIN does not advance hours.
REQ-024 SHALL hold ctl_enable = 1 whenever not in reset.
REQ-025 SHALL drive ctl_blink constant 1 in RUN; in set modes it SHALL toggle every BLINK_TICKS cycles, starting at 1 on mode entry, and its counter SHALL restart at each mode change.
REQ-026 SHALL start the auto-repeat counter at the inc rising edge and clear it when ctl_btn_inc = 0 or the mode changes.
REQ-027 SHALL give mode priority when a mode edge coincides with an inc edge, repeat pulse or prescaler minute wrap: the mode change occurs, and no add pulse is emitted that cycle.
REQ-028 SHALL drive registered outputs only, with no combinational path from any input to any output.
REQ-029 SHALL never assert ctl_add_min and ctl_add_hor in the same cycle.

Reset
REQ-030 SHALL, while ctl_reset = 1 and independent of the clock, force: state RUN, prescaler 0, ctl_sec 0, ctl_add_min 0, ctl_add_hor 0, ctl_carry_en 1, ctl_enable 0, ctl_mode 0, ctl_blink 1, and the button-history registers 0.
REQ-031 SHALL set ctl_enable to 1 on the first clock edge after ctl_reset deasserts.
REQ-032 SHALL, on reset asserted mid-operation (any state, during a pulse), drop the pulse immediately; a button already high at release SHALL NOT produce an edge.

Verification (TICKS_PER_SEC=4, SEC_PER_MIN=3, REPEAT_TICKS=5, BLINK_TICKS=2)
REQ-033 SHALL cover: reset release, RUN, no buttons -> ctl_add_min pulses 1 cycle every 12 cycles, ctl_sec sequence 0,1,2,0, ctl_carry_en=1.
REQ-034 SHALL cover: one mode press -> ctl_mode=1, ctl_sec=0; inc held 12 cycles -> ctl_add_hor pulses at edge+0, +5 and +10; no ctl_add_min.
REQ-035 SHALL cover: second mode press -> ctl_mode=2, ctl_carry_en=0; 3 single inc presses -> 3 ctl_add_min pulses; ctl_blink toggles every 2 cycles.
REQ-036 SHALL cover: mode and inc rising in the same cycle in SET_MIN -> ctl_mode=0, no pulse; first ctl_add_min 12 cycles later.
REQ-037 SHALL cover: mode press on the exact prescaler/second wrap cycle in RUN -> ctl_mode=1, no ctl_add_min.
REQ-038 SHALL cover: ctl_reset asserted mid-SET_HOR with inc held -> outputs at reset values asynchronously; after release, no pulse until inc drops and rises again.

Source files
------------

// File: rtl/ctl_relogio.sv
// ctl_relogio: control unit for a clock display with run / set-hour / set-minute modes.
// Generates seconds, minute pulses, set-mode increment pulses with auto-repeat and a
// blink flag for the field being edited. All outputs come straight from flops.
module ctl_relogio #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int SEC_PER_MIN   = 60,
  parameter int REPEAT_TICKS  = 25000000,
  parameter int BLINK_TICKS   = 12500000
) (
  input  logic       ctl_clock,
  input  logic       ctl_reset,
  input  logic       ctl_btn_mode,
  input  logic       ctl_btn_inc,
  output logic       ctl_enable,
  output logic       ctl_add_min,
  output logic       ctl_add_hor,
  output logic       ctl_carry_en,
  output logic [1:0] ctl_mode,
  output logic [5:0] ctl_sec,
  output logic       ctl_blink
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HOR = 2'd1,
    SET_MIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_act_q, rep_act_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          add_min_q, add_min_d;
  logic          add_hor_q, add_hor_d;
  logic          carry_q, carry_d;
  logic          enable_q, enable_d;
  logic          mode_prev_q, mode_prev_d;
  logic          inc_prev_q, inc_prev_d;
  logic          mode_edge, inc_edge, inc_fire;

  // Edges are ignored on the first edge after reset so a button held through reset
  // release only loads the history registers instead of looking like a fresh press.
  always_comb begin
    mode_edge = enable_q & ctl_btn_mode & ~mode_prev_q;
    inc_edge  = enable_q & ctl_btn_inc & ~inc_prev_q;
  end

  // Next-state logic: mode changes win over everything, then run-mode timekeeping
  // or set-mode increment / auto-repeat / blink handling.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    sec_d       = sec_q;
    rep_cnt_d   = rep_cnt_q;
    rep_act_d   = rep_act_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    add_min_d   = 1'b0;
    add_hor_d   = 1'b0;
    enable_d    = 1'b1;
    mode_prev_d = ctl_btn_mode;
    inc_prev_d  = ctl_btn_inc;
    inc_fire    = 1'b0;

    if (mode_edge) begin
      case (state_q)
        RUN:     state_d = SET_HOR;
        SET_HOR: state_d = SET_MIN;
        default: state_d = RUN;
      endcase
      presc_d     = '0;
      sec_d       = '0;
      rep_cnt_d   = '0;
      rep_act_d   = 1'b0;
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (state_q == RUN) begin
      rep_cnt_d   = '0;
      rep_act_d   = 1'b0;
      blink_cnt_d = '0;
      blink_d     = 1'b1;
      if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
        presc_d = '0;
        if (sec_q == 6'(SEC_PER_MIN - 1)) begin
          sec_d     = '0;
          add_min_d = 1'b1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
      sec_d   = '0;
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
      if (!ctl_btn_inc) begin
        rep_act_d = 1'b0;
        rep_cnt_d = '0;
      end else if (inc_edge) begin
        inc_fire  = 1'b1;
        rep_act_d = 1'b1;
        rep_cnt_d = '0;
      end else if (rep_act_q) begin
        if (rep_cnt_q == RW'(REPEAT_TICKS - 1)) begin
          inc_fire  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      if (inc_fire) begin
        if (state_q == SET_MIN) add_min_d = 1'b1;
        else                    add_hor_d = 1'b1;
      end
    end

    carry_d = (state_d == RUN);
  end

  // State register with asynchronous reset to the run-mode idle values.
  always_ff @(posedge ctl_clock or posedge ctl_reset) begin
    if (ctl_reset) begin
      state_q     <= RUN;
      presc_q     <= '0;
      sec_q       <= '0;
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      add_min_q   <= 1'b0;
      add_hor_q   <= 1'b0;
      carry_q     <= 1'b1;
      enable_q    <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      add_min_q   <= add_min_d;
      add_hor_q   <= add_hor_d;
      carry_q     <= carry_d;
      enable_q    <= enable_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
    end
  end

  assign ctl_enable   = enable_q;
  assign ctl_add_min  = add_min_q;
  assign ctl_add_hor  = add_hor_q;
  assign ctl_carry_en = carry_q;
  assign ctl_mode     = state_q;
  assign ctl_sec      = sec_q;
  assign ctl_blink    = blink_q;

endmodule
